// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to end MUL once remaining multiplier bits are zero.
module mips_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIXUP, DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod, mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem, quo, dvs, raw_a;
  logic              neg_p, neg_q, neg_r;
  logic              dz, is_div;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] p_fix;
  logic [XLEN-1:0]   q_fix, r_fix;
  logic              early;
  logic              last;

  always_comb begin
    sgn_a = ~op_i[0] & a_i[XLEN-1];
    sgn_b = ~op_i[0] & b_i[XLEN-1];
    mag_a = sgn_a ? -a_i : a_i;
    mag_b = sgn_b ? -b_i : b_i;
  end

  // Restoring step: trial subtract of the shifted partial remainder.
  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvs};

  assign p_fix = neg_p ? -prod : prod;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (mplier[XLEN-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  assign last   = (cnt == CNT_W'(1));
  assign busy_o = (state == MUL) || (state == DIV) || (state == FIXUP);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_i) state_n = op_i[1] ? DIV : MUL;
      MUL: begin
        if (flush_i)            state_n = IDLE;
        else if (last || early) state_n = FIXUP;
      end
      DIV: begin
        if (flush_i)   state_n = IDLE;
        else if (last) state_n = FIXUP;
      end
      FIXUP: state_n = flush_i ? IDLE : DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      raw_a  <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cnt    <= CNT_W'(XLEN);
            prod   <= '0;
            mcand  <= {{XLEN{1'b0}}, mag_a};
            mplier <= mag_b;
            rem    <= '0;
            quo    <= mag_a;
            dvs    <= mag_b;
            raw_a  <= a_i;
            neg_p  <= sgn_a ^ sgn_b;
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            dz     <= (b_i == '0);
            is_div <= op_i[1];
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
        end
        DIV: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
        end
        FIXUP: begin
          if (!flush_i) begin
            if (!is_div) begin
              hi_o <= p_fix[2*XLEN-1:XLEN];
              lo_o <= p_fix[XLEN-1:0];
            end else if (dz) begin
              hi_o <= raw_a;
              lo_o <= '1;
            end else begin
              hi_o <= r_fix;
              lo_o <= q_fix;
            end
          end
        end
        default: ;
      endcase
      // MTHI/MTLO only land while no result write can be pending
      if (!busy_o) begin
        if (hi_we_i) hi_o <= wdata_i;
        if (lo_we_i) lo_o <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit.
// Expected HI/LO and completion cycle are queued at launch, checked on done.
module tb_mips_muldiv_unit;

  localparam int X = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [X-1:0]  a = '0;
  logic [X-1:0]  b = '0;
  logic          flush = 1'b0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [X-1:0]  wdata = '0;
  logic          busy, done;
  logic [X-1:0]  hi, lo;

  mips_muldiv_unit #(.XLEN(X)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .wdata_i (wdata),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [X-1:0] hi;
    logic [X-1:0] lo;
    int           at;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [X-1:0] last_hi = '0;
  logic [X-1:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o, input logic [X-1:0] bb);
    logic [X-1:0] mb;
    int k;
    lat_of = X + 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mb = (o == 2'b00 && bb[X-1]) ? -bb : bb;
      k = 1;
      for (int i = 0; i < X; i++) if (mb[i]) k = i + 1;
      lat_of = 2 + k;
    end
`else
    mb = '0;
    k = int'(mb[0]) + int'(o[0]) + int'(bb[0]);
`endif
  endfunction

  task automatic model(input logic [1:0] o, input logic [X-1:0] aa,
                       input logic [X-1:0] bb,
                       output logic [X-1:0] h, output logic [X-1:0] l);
    longint       sp;
    logic [63:0]  up;
    int           sa, sbv;
    sa  = aa;
    sbv = bb;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sbv);
        up = sp;
        h = up[63:32];
        l = up[31:0];
      end
      2'b01: begin
        up = {32'h0, aa} * {32'h0, bb};
        h = up[63:32];
        l = up[31:0];
      end
      default: begin
        if (bb == '0) begin
          h = aa;
          l = '1;
        end else if (o == 2'b10 && aa == 32'h8000_0000 && bb == '1) begin
          h = '0;
          l = 32'h8000_0000;
        end else if (o == 2'b10) begin
          h = sa % sbv;
          l = sa / sbv;
        end else begin
          h = aa % bb;
          l = aa / bb;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("done_cycle", cyc, e.at);
      end
    end
  end

  // Called just after a falling edge; returns one cycle later.
  task automatic launch(input logic [1:0] o, input logic [X-1:0] aa,
                        input logic [X-1:0] bb, input bit push);
    exp_t e;
    op = o;
    a = aa;
    b = bb;
    start = 1'b1;
    if (push) begin
      model(o, aa, bb, e.hi, e.lo);
      e.at = cyc + lat_of(o, bb);
      sb.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] o, input logic [X-1:0] aa,
                     input logic [X-1:0] bb);
    launch(o, aa, bb, 1);
    wait_done();
  endtask

  initial begin
    int L;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -3*7 with busy/done timing
    L = lat_of(2'b00, 32'd7);
    launch(2'b00, 32'hFFFF_FFFD, 32'd7, 1);
    check("busy_first", busy, 1);
    repeat (L - 2) @(negedge clk);
    check("busy_last", busy, 1);
    check("done_early", done, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_once", done, 0);

    run(2'b11, 32'd100, 32'd7);
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b11, 32'h0000_1234, 32'h0);
    run(2'b10, 32'hFFFF_FFF0, 32'h0);
    run(2'b10, 32'd7, 32'hFFFF_FFFE);
    run(2'b01, 32'd9, 32'd1);
    run(2'b00, 32'h1234_5678, 32'h0);
    run(2'b00, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom_range(0, 3));
      run(ro, $urandom, (i < 3) ? 32'($urandom_range(1, 20)) : $urandom);
    end

    // flush mid-MULTU: no result, HI/LO keep prior values
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hi", hi, last_hi);
    check("flush_lo", lo, last_lo);
    @(negedge clk);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'hA5A5_A5A5);
    lo_we = 1'b1;
    wdata = 32'h0F0F_0F0F;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'h0F0F_0F0F);

    // MTLO and start during MUL are both ignored
    launch(2'b01, 32'h1234, 32'h100, 1);
    repeat (4) @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    op = 2'b11;
    start = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    start = 1'b0;
    check("mtlo_busy", lo, 32'h0F0F_0F0F);
    check("busy_mid", busy, 1);
    wait_done();

    // MTHI together with start: write now, result overwrites later
    hi_we = 1'b1;
    wdata = 32'h77;
    launch(2'b11, 32'd50, 32'd6, 1);
    hi_we = 1'b0;
    check("mthi_start", hi, 32'h77);
    wait_done();

    // reset during DIV: everything clears, no done
    launch(2'b10, 32'd1000, 32'd3, 0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
